// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl -- iterative divide controller for the EX stage (DIV / DIVU).
//
// Restoring division, one quotient bit per clock, on the absolute values of
// the operands. The quotient and remainder are sign-corrected as the block
// enters DONE. result_o is {remainder, quotient} and feeds {HI, LO}.
//
// Optional feature: define DIV_ZERO_FAST_EN to send a zero divisor through a
// short ZERO state (result 0, two-cycle latency). Without the macro a zero
// divisor runs all iterations: raw quotient all ones, raw remainder |dividend|.
//
// Handshake: start_i is a level request. It is accepted on the rising edge
// where the block is IDLE, start_i=1 and annul_i=0. The requester keeps
// start_i high until it sees ready_o. ready_o/result_o stay valid for as long
// as start_i is held in DONE, and the block returns to IDLE on the first edge
// with start_i=0. annul_i abandons whatever is in flight on the next edge.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous reset, active low
//   start_i        divide request, held until ready_o
//   annul_i        cancel in-flight divide (flush / exception)
//   signed_div_i   1 = DIV (two's complement), 0 = DIVU
//   opdata1_i      dividend, sampled on acceptance
//   opdata2_i      divisor, sampled on acceptance
//   result_o       {remainder, quotient}, valid while ready_o=1, else 0
//   ready_o        result valid
//   stallreq_o     combinational stall request to the pipeline
//   state_o        FSM state for observation (IDLE=0, ZERO=1, RUN=2, DONE=3)
module ex_div_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                annul_i,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stallreq_o,
  output logic [1:0]          state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef DIV_ZERO_FAST_EN
    ZERO = 2'd1,
`endif
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [5:0] LAST_ITER = 6'(DATA_W - 1);

  state_e                state_q,   state_d;
  logic [5:0]            cnt_q,     cnt_d;
  logic [DATA_W-1:0]     rem_q,     rem_d;
  logic [DATA_W-1:0]     quo_q,     quo_d;
  logic [DATA_W-1:0]     dvsr_q,    dvsr_d;
  logic                  signed_q,  signed_d;
  logic                  op1_neg_q, op1_neg_d;
  logic                  op2_neg_q, op2_neg_d;
  logic                  ready_q,   ready_d;
  logic [2*DATA_W-1:0]   result_q,  result_d;

  logic [DATA_W:0]       trial;
  logic [DATA_W:0]       diff;
  logic                  step_ge;
  logic [DATA_W-1:0]     rem_step;
  logic [DATA_W-1:0]     quo_step;
  logic [DATA_W-1:0]     quo_fix;
  logic [DATA_W-1:0]     rem_fix;
  logic [DATA_W-1:0]     op1_abs;
  logic [DATA_W-1:0]     op2_abs;
  logic                  go_idle;

  // quo_q starts as |dividend| and doubles as the shift register feeding
  // dividend bits into the partial remainder from the MSB end, while quotient
  // bits enter from the LSB end.
  assign trial    = {rem_q, quo_q[DATA_W-1]};
  assign diff     = trial - {1'b0, dvsr_q};
  assign step_ge  = ~diff[DATA_W];
  assign rem_step = step_ge ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
  assign quo_step = {quo_q[DATA_W-2:0], step_ge};

  // Sign correction: quotient negative when operand signs differ, remainder
  // follows the dividend. -MIN wraps to MIN, so MIN / -1 gives MIN, rem 0.
  assign quo_fix  = (signed_q & (op1_neg_q ^ op2_neg_q)) ? -quo_step : quo_step;
  assign rem_fix  = (signed_q & op1_neg_q) ? -rem_step : rem_step;

  assign op1_abs  = (signed_div_i & opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign op2_abs  = (signed_div_i & opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    signed_d  = signed_q;
    op1_neg_d = op1_neg_q;
    op2_neg_d = op2_neg_q;
    ready_d   = ready_q;
    result_d  = result_q;
    go_idle   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i && !annul_i) begin
          signed_d  = signed_div_i;
          op1_neg_d = signed_div_i & opdata1_i[DATA_W-1];
          op2_neg_d = signed_div_i & opdata2_i[DATA_W-1];
          quo_d     = op1_abs;
          dvsr_d    = op2_abs;
          rem_d     = '0;
          cnt_d     = '0;
`ifdef DIV_ZERO_FAST_EN
          state_d   = (opdata2_i == '0) ? ZERO : RUN;
`else
          state_d   = RUN;
`endif
        end
      end
`ifdef DIV_ZERO_FAST_EN
      ZERO: begin
        if (annul_i) begin
          go_idle = 1'b1;
        end else begin
          state_d  = DONE;
          ready_d  = 1'b1;
          result_d = '0;
        end
      end
`endif
      RUN: begin
        if (annul_i) begin
          go_idle = 1'b1;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          if (cnt_q == LAST_ITER) begin
            state_d  = DONE;
            cnt_d    = '0;
            ready_d  = 1'b1;
            result_d = {rem_fix, quo_fix};
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      DONE: begin
        if (annul_i || !start_i) begin
          go_idle = 1'b1;
        end
      end
      default: go_idle = 1'b1;
    endcase

    // Leaving for IDLE always discards the latched operands and result.
    if (go_idle) begin
      state_d   = IDLE;
      cnt_d     = '0;
      rem_d     = '0;
      quo_d     = '0;
      dvsr_d    = '0;
      signed_d  = 1'b0;
      op1_neg_d = 1'b0;
      op2_neg_d = 1'b0;
      ready_d   = 1'b0;
      result_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      signed_q  <= 1'b0;
      op1_neg_q <= 1'b0;
      op2_neg_q <= 1'b0;
      ready_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      signed_q  <= signed_d;
      op1_neg_q <= op1_neg_d;
      op2_neg_q <= op2_neg_d;
      ready_q   <= ready_d;
      result_q  <= result_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign state_o    = state_q;
  assign stallreq_o = start_i & ~annul_i & (state_q != DONE);

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Testbench for ex_div_ctrl (DATA_W = 32). Honours DIV_ZERO_FAST_EN the same
// way as the design. Latency is counted in cycles with the acceptance cycle
// (the cycle that ends in the accepting edge) as cycle 0.
module tb_ex_div_ctrl;
  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic           start_i;
  logic           annul_i;
  logic           signed_div_i;
  logic [W-1:0]   opdata1_i;
  logic [W-1:0]   opdata2_i;
  logic [2*W-1:0] result_o;
  logic           ready_o;
  logic           stallreq_o;
  logic [1:0]     state_o;

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc   = 0;

  // {acceptance cycle[31:0], latency[7:0], result[63:0]}
  logic [103:0] exp_q[$];

  ex_div_ctrl #(.DATA_W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o),
    .state_o      (state_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] ua, ub, q, r;
    bit na, nb;
`ifdef DIV_ZERO_FAST_EN
    if (b == 32'd0) return 64'd0;
`endif
    na = s && a[31];
    nb = s && b[31];
    ua = na ? -a : a;
    ub = nb ? -b : b;
    if (ub == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = ua;
    end else begin
      q = ua / ub;
      r = ua % ub;
    end
    if (na ^ nb) q = -q;
    if (na) r = -r;
    return {r, q};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic         prev_ready;
    logic [103:0] e;
    int           lat;
    prev_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_ready = 1'b0;
      end else begin
        if (ready_o && !prev_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_ready", 64'(ready_o), 64'd0);
          end else begin
            e   = exp_q.pop_front();
            lat = int'(cyc - e[103:72]) + 1;
            check("result", result_o, e[63:0]);
            check("latency", 64'(lat), 64'(e[71:64]));
            if (start_i) check("stall_in_done", 64'(stallreq_o), 64'd0);
          end
        end
        if (!ready_o) check("result_zero_not_ready", result_o, 64'd0);
        prev_ready = ready_o;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All driver tasks start just after a falling edge and return the same way.
  task automatic pulse_reset();
    #1;
    rst     = 1'b0;
    start_i = 1'b0;
    annul_i = 1'b0;
    #2;
    rst     = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic expect_quiet(input int n, input string name);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (ready_o) seen = 1'b1;
    end
    check(name, 64'(seen), 64'd0);
    #1;
  endtask

  task automatic do_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit kill);
    int lat;
    int n;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    lat = 33;
`ifdef DIV_ZERO_FAST_EN
    if (b == 32'd0) lat = 2;
`endif
    exp_q.push_back({32'(cyc + 1), 8'(lat), ref_div(s, a, b)});
    @(negedge clk);
    check("stall_busy", 64'(stallreq_o), 64'd1);
    // Operands may wander once accepted; the result must not follow them.
    #1;
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = 1'($urandom);
    n = 0;
    while (!ready_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      check("ready_timeout", 64'(ready_o), 64'd1);
      if (exp_q.size() != 0) void'(exp_q.pop_back());
      pulse_reset();
      return;
    end
    if (kill) begin
      #1;
      annul_i = 1'b1;
      @(negedge clk);
      check("annul_in_done", 64'(ready_o), 64'd0);
      #1;
      annul_i = 1'b0;
      start_i = 1'b0;
      @(negedge clk);
      #1;
      return;
    end
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      check("hold_ready", 64'(ready_o), 64'd1);
    end
    #1;
    start_i = 1'b0;
    @(negedge clk);
    check("drop_to_idle", 64'(ready_o), 64'd0);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a, b;
    bit          s;
    rst          = 1'b0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;

    #12;
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    check("reset_state", 64'(state_o), 64'd0);
    check("reset_stall_idle", 64'(stallreq_o), 64'd0);
    start_i = 1'b1;
    #1;
    check("reset_stall_req", 64'(stallreq_o), 64'd1);
    start_i = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    #1;

    // Directed cases
    do_div(1'b0, 32'd100, 32'd7, 1, 1'b0);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1, 1'b0);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1'b0);
    do_div(1'b0, 32'd5, 32'd0, 1, 1'b0);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd0, 1, 1'b0);
    do_div(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1, 1'b0);
    do_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1, 1'b0);
    // Held three cycles in DONE, then back-to-back restart
    do_div(1'b0, 32'd1000, 32'd3, 3, 1'b0);
    do_div(1'b1, 32'd1000, 32'hFFFF_FFFD, 2, 1'b0);
    // annul while DONE
    do_div(1'b0, 32'd77, 32'd5, 1, 1'b1);

    // annul during RUN after ten iterations
    start_i      = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = $urandom;
    opdata2_i    = $urandom | 32'd1;
    repeat (11) @(negedge clk);
    #1;
    annul_i = 1'b1;
    @(negedge clk);
    check("stall_annul", 64'(stallreq_o), 64'd0);
    #1;
    annul_i = 1'b0;
    start_i = 1'b0;
    expect_quiet(40, "quiet_after_annul");
    do_div(1'b0, 32'd9, 32'd3, 1, 1'b0);

    // start with annul in IDLE is ignored
    start_i = 1'b1;
    annul_i = 1'b1;
    repeat (3) @(negedge clk);
    check("stall_start_annul", 64'(stallreq_o), 64'd0);
    #1;
    start_i = 1'b0;
    annul_i = 1'b0;
    expect_quiet(40, "quiet_after_ignored_start");

    // reset between edges mid-RUN
    start_i      = 1'b1;
    signed_div_i = 1'b1;
    opdata1_i    = $urandom;
    opdata2_i    = $urandom | 32'd1;
    repeat (15) @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("midrun_reset_ready", 64'(ready_o), 64'd0);
    check("midrun_reset_result", result_o, 64'd0);
    check("midrun_reset_state", 64'(state_o), 64'd0);
    check("midrun_reset_stall", 64'(stallreq_o), 64'd1);
    start_i = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    expect_quiet(40, "quiet_after_reset");

    // Randomised traffic
    repeat (24) begin
      s = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = $urandom;
        default: b = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      do_div(s, a, b, $urandom_range(1, 3), ($urandom_range(0, 7) == 0));
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
